// File: rtl/dacw_pkg.sv
// Shared types and timing defaults for the DAC0832 write sequencer.
// Phase counter width is derived from the longest phase so the down-counter never wraps.
package dacw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR1_LOW,
    HOLD1,
    XFER_LOW,
    HOLD2
  } state_t;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_WR_CYC    = 40;
  localparam int DEF_HOLD_CYC  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Smallest width that can hold max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

  localparam int DEF_CNT_W = cnt_width(max3(DEF_SETUP_CYC, DEF_WR_CYC, DEF_HOLD_CYC));

endpackage

// File: rtl/dacw_phase_timer.sv
// Loadable down-counter timing one write-sequence phase; zero flag marks the last cycle of a phase.
// Load wins over decrement; the count parks at zero rather than wrapping.
module dacw_phase_timer
  import dacw_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dac0832_writer.sv
// DAC0832 write sequencer: latches one sample per handshake and strobes it in; DACW_DOUBLE_BUF_EN adds the XFER phase.
// Busy for SETUP+WR+HOLD cycles (+WR+HOLD double-buffered); sample_ready low while busy, upstream must hold its sample.
module dac0832_writer
  import dacw_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int WR_CYC    = DEF_WR_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic       sample_ready,
  output logic       write_done,
  output logic [7:0] dac_data,
  output logic       DAC_ILE,
  output logic       DAC_CS,
  output logic       DAC_WR1,
  output logic       DAC_WR2,
  output logic       DAC_XFER
);

  localparam int CNT_W = cnt_width(max3(SETUP_CYC, WR_CYC, HOLD_CYC));
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t           state, state_nxt;
  logic [7:0]       data_nxt;
  logic             cs_nxt, wr1_nxt, wr2_nxt, xfer_nxt;
  logic             ready_nxt, done_nxt;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  dacw_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    data_nxt  = dac_data;
    cs_nxt    = DAC_CS;
    wr1_nxt   = DAC_WR1;
`ifdef DACW_DOUBLE_BUF_EN
    wr2_nxt   = DAC_WR2;
    xfer_nxt  = DAC_XFER;
`else
    // Flow-through DAC register: WR2/XFER parked low once out of reset.
    wr2_nxt   = 1'b0;
    xfer_nxt  = 1'b0;
`endif
    ready_nxt = sample_ready;
    done_nxt  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = SETUP_LD;

    case (state)
      IDLE: begin
        if (sample_valid && sample_ready) begin
          data_nxt  = sample_data;
          cs_nxt    = 1'b0;
          ready_nxt = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = SETUP_LD;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          wr1_nxt   = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = WR_LD;
          state_nxt = WR1_LOW;
        end
      end
      WR1_LOW: begin
        if (tmr_zero) begin
          wr1_nxt   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LD;
          state_nxt = HOLD1;
        end
      end
      HOLD1: begin
        if (tmr_zero) begin
          cs_nxt = 1'b1;
`ifdef DACW_DOUBLE_BUF_EN
          wr2_nxt   = 1'b0;
          xfer_nxt  = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = WR_LD;
          state_nxt = XFER_LOW;
`else
          done_nxt  = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
`ifdef DACW_DOUBLE_BUF_EN
      XFER_LOW: begin
        if (tmr_zero) begin
          wr2_nxt   = 1'b1;
          xfer_nxt  = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LD;
          state_nxt = HOLD2;
        end
      end
      HOLD2: begin
        if (tmr_zero) begin
          done_nxt  = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dac_data     <= 8'h00;
      DAC_ILE      <= 1'b1;
      DAC_CS       <= 1'b1;
      DAC_WR1      <= 1'b1;
      DAC_WR2      <= 1'b1;
      DAC_XFER     <= 1'b1;
      sample_ready <= 1'b1;
      write_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      dac_data     <= data_nxt;
      DAC_ILE      <= 1'b1;
      DAC_CS       <= cs_nxt;
      DAC_WR1      <= wr1_nxt;
      DAC_WR2      <= wr2_nxt;
      DAC_XFER     <= xfer_nxt;
      sample_ready <= ready_nxt;
      write_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dac0832_writer.sv
// Bench for dac0832_writer: default-timing instance plus an all-ones-timing instance, checked against a timeline model.
// Define DACW_DOUBLE_BUF_EN for both RTL and bench to exercise the double-buffered sequence.
module tb_dac0832_writer;

`ifdef DACW_DOUBLE_BUF_EN
  localparam bit DB     = 1'b1;
  localparam int NA_LIT = 86;
  localparam int NB_LIT = 5;
`else
  localparam bit DB     = 1'b0;
  localparam int NA_LIT = 44;
  localparam int NB_LIT = 3;
`endif

  logic       clk;
  logic       rst;
  logic       vld [2];
  logic [7:0] sd  [2];
  logic       rdy [2];
  logic       dn  [2];
  logic [7:0] dd  [2];
  logic       ile [2];
  logic       cs  [2];
  logic       wr1 [2];
  logic       wr2 [2];
  logic       xf  [2];

  int checks = 0;
  int errors = 0;
  bit stream = 1'b0;

  dac0832_writer dut_a (
    .clk(clk), .rst(rst),
    .sample_valid(vld[0]), .sample_data(sd[0]), .sample_ready(rdy[0]), .write_done(dn[0]),
    .dac_data(dd[0]), .DAC_ILE(ile[0]), .DAC_CS(cs[0]), .DAC_WR1(wr1[0]),
    .DAC_WR2(wr2[0]), .DAC_XFER(xf[0])
  );

  dac0832_writer #(.SETUP_CYC(1), .WR_CYC(1), .HOLD_CYC(1)) dut_b (
    .clk(clk), .rst(rst),
    .sample_valid(vld[1]), .sample_data(sd[1]), .sample_ready(rdy[1]), .write_done(dn[1]),
    .dac_data(dd[1]), .DAC_ILE(ile[1]), .DAC_CS(cs[1]), .DAC_WR1(wr1[1]),
    .DAC_WR2(wr2[1]), .DAC_XFER(xf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- timeline model ----------------
  int         sp [2] = '{2, 1};
  int         wp [2] = '{40, 1};
  int         hp [2] = '{2, 1};
  int         cyc = 0;
  int         t_acc [2];
  bit         have  [2];
  bit         post  [2];
  logic [7:0] mdata [2];

  function automatic int occ(input int i);
    return sp[i] + wp[i] + hp[i] + (DB ? wp[i] + hp[i] : 0);
  endfunction

  function automatic int age(input int i);
    return have[i] ? (cyc - t_acc[i]) : 1000000;
  endfunction

  // {data, ile, cs, wr1, wr2, xfer, ready, done}
  function automatic logic [14:0] model_out(input int i);
    int  e, s, w, h;
    logic cs_e, wr1_e, wx_e;
    if (rst || !post[i]) return {mdata[i], 7'b1111110};
    e = age(i); s = sp[i]; w = wp[i]; h = hp[i];
    cs_e  = !(e < s + w + h);
    wr1_e = !(e >= s && e < s + w);
    wx_e  = DB ? !(e >= s + w + h && e < s + 2 * w + h) : 1'b0;
    return {mdata[i], 1'b1, cs_e, wr1_e, wx_e, wx_e, !(e < occ(i)), (e == occ(i))};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        have[i] = 1'b0; post[i] = 1'b0; mdata[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (vld[i] && age(i) >= occ(i)) begin
          t_acc[i] = cyc + 1; mdata[i] = sd[i]; have[i] = 1'b1;
        end
        post[i] = 1'b1;
      end
      cyc = cyc + 1;
    end
  end

  // ---------------- compare process ----------------
  int s_lit  [2] = '{2, 1};
  int w_lit  [2] = '{40, 1};
  int cs_lit [2] = '{44, 3};
  int n_lit  [2] = '{NA_LIT, NB_LIT};
  bit in_tx  [2];
  int acc_c  [2];
  int wr1_cnt[2], wr2_cnt[2], cs_cnt[2], wr1_first[2];
  int prev_acc;
  bit prev_ok = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk or posedge rst) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [14:0] got, exp;
      got = {dd[i], ile[i], cs[i], wr1[i], wr2[i], xf[i], rdy[i], dn[i]};
      exp = model_out(i);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL outputs inst%0d at %0t: got data=%h ile/cs/wr1/wr2/xfer/rdy/done=%b expected data=%h flags=%b",
                 i, $time, got[14:7], got[6:0], exp[14:7], exp[6:0]);
      end
    end
    if (!stream) prev_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        in_tx[i] = 1'b0;
      end else begin
        if (in_tx[i]) begin
          if (!wr1[i]) begin
            wr1_cnt[i]++;
            if (wr1_first[i] < 0) wr1_first[i] = cyc - acc_c[i];
          end
          if (!cs[i])  cs_cnt[i]++;
          if (!wr2[i]) wr2_cnt[i]++;
          if (dn[i]) begin
            chk($sformatf("done_latency%0d", i), cyc - acc_c[i], n_lit[i]);
            chk($sformatf("wr1_width%0d", i), wr1_cnt[i], w_lit[i]);
            chk($sformatf("cs_to_wr1_%0d", i), wr1_first[i], s_lit[i]);
            chk($sformatf("cs_width%0d", i), cs_cnt[i], cs_lit[i]);
`ifdef DACW_DOUBLE_BUF_EN
            chk($sformatf("wr2_width%0d", i), wr2_cnt[i], w_lit[i]);
`endif
            in_tx[i] = 1'b0;
          end
        end
        if (rdy[i] && vld[i]) begin
          if (i == 0) begin
            if (stream && prev_ok) chk("accept_spacing", cyc + 1 - prev_acc, NA_LIT + 1);
            prev_acc = cyc + 1;
            prev_ok  = stream;
          end
          in_tx[i] = 1'b1; acc_c[i] = cyc + 1;
          wr1_cnt[i] = 0; wr2_cnt[i] = 0; cs_cnt[i] = 0; wr1_first[i] = -1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0; sd[0] = 8'h00; sd[1] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single sample
    vld[0] = 1'b1; sd[0] = 8'hA5;
    @(negedge clk);
    vld[0] = 1'b0; sd[0] = 8'h00;
    repeat (NA_LIT + 10) @(negedge clk);

    // back-to-back stream, valid held high
    stream = 1'b1;
    vld[0] = 1'b1; sd[0] = 8'h00;
    @(negedge clk);
    sd[0] = 8'hFF;
    repeat (NA_LIT + 1) @(negedge clk);
    sd[0] = 8'h80;
    repeat (NA_LIT + 1) @(negedge clk);
    vld[0] = 1'b0;
    repeat (NA_LIT + 10) @(negedge clk);
    stream = 1'b0;

    // data toggling while busy must be ignored
    vld[0] = 1'b1; sd[0] = 8'h11;
    @(negedge clk);
    for (int j = 0; j < 20; j++) begin
      sd[0] = ~sd[0];
      @(negedge clk);
    end
    vld[0] = 1'b0;
    repeat (NA_LIT + 10) @(negedge clk);

    // asynchronous reset in the middle of the WR1 pulse
    vld[0] = 1'b1; sd[0] = 8'h5A;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (10) @(negedge clk);
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (NA_LIT + 10) @(negedge clk);

    vld[0] = 1'b1; sd[0] = 8'h3C;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (NA_LIT + 10) @(negedge clk);

    // minimum-timing instance: single write, then a continuous stream
    vld[1] = 1'b1; sd[1] = 8'h3C;
    @(negedge clk);
    vld[1] = 1'b0;
    repeat (10) @(negedge clk);
    vld[1] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      sd[1] = 8'(j * 17 + 3);
      @(negedge clk);
    end
    vld[1] = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
